sync_fifo_top: RTL and testbench
================================

Name: sync_fifo_top

Overview:
- Single-clock, 16-entry x 32-bit first-in first-out buffer with registered read data and full/empty flags.
- Sits between a word producer (winc/wdata) and a consumer (rinc/rdata) in the same clock domain.
- The producer throttles on wfull and the consumer throttles on rempty.
- Storage is a register array addressed by wrap-around binary pointers that carry one extra bit for full/empty disambiguation.

Parameters:
- DSIZE, 32, data word width in bits.
- ASIZE, 4, address width; depth = 2**ASIZE = 16 entries.

Ports:
- wclk  input  1  the single clock for the whole block; all state updates on its rising edge.
- wrst  input  1  reset, synchronous and active-high; sampled on the wclk rising edge.
- winc  input  1  write request; a word is accepted when winc=1 and wfull=0.
- wdata  input  DSIZE  write data, captured with an accepted write.
- rinc  input  1  read request; a word is popped when rinc=1 and rempty=0.
- rdata  output  DSIZE  read data register, loaded with the popped word.
- wfull  output  1  FIFO holds 16 words.
- rempty  output  1  FIFO holds 0 words.
- count  output  ASIZE+1  current occupancy, 0..16.

Behaviour:
- Internal state:
  - mem[0:15] of DSIZE bits.
  - wptr and rptr, each ASIZE+1 bits.
  - The low ASIZE bits of each pointer address mem.
- Reset (wrst=1 at a rising edge):
  - wptr=0, rptr=0, rdata=0, wfull=0, rempty=1, count=0.
  - mem contents are not cleared and are don't-care.
  - Reset has priority over winc/rinc in the same cycle.
  - Reset asserted mid-operation discards all stored words.
- Write:
  - Condition: we = winc & ~wfull.
  - Action: mem[wptr[ASIZE-1:0]] <= wdata; wptr <= wptr+1, wrapping modulo 2**(ASIZE+1).
  - winc while full is ignored: no pointer change and no data corruption.
- Read:
  - Condition: re = rinc & ~rempty.
  - Action: rdata <= mem[rptr[ASIZE-1:0]]; rptr <= rptr+1.
  - Latency: rdata is valid the cycle after the accepted read edge (1-cycle registered).
  - rdata holds its value when no read is accepted.
  - rinc while empty is ignored: rdata and pointers are unchanged.
- Flags (registered):
  - Computed from the next-state pointers so they are valid in the same cycle the pointers update.
  - rempty = (wptr_next == rptr_next).
  - wfull = (wptr_next[ASIZE] != rptr_next[ASIZE]) and (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]).
  - count = wptr_next - rptr_next, modulo 2**(ASIZE+1).
- Simultaneous winc and rinc:
  - Both accepted when not full and not empty; count unchanged.
  - When empty: only the write is accepted; the read is blocked; rempty deasserts the next cycle.
  - When full: only the read is accepted; the write is blocked; wfull deasserts the next cycle.
  - A write and a read are never accepted to the same empty slot in one cycle, so no bypass path is required.
- Wrap-around: pointers roll from 31 to 0 with addresses 15 to 0; ordering is preserved across the wrap.
- Invariants:
  - wfull and rempty are never both 1.
  - count==16 iff wfull.
  - count==0 iff rempty.

Test Plan:
- Reset: hold wrst=1 for 2 cycles with winc=rinc=1 -> rempty=1, wfull=0, count=0, rdata=0, no state change.
- Fill: write 0x00000000..0x0000000F with rinc=0 -> wfull=1 after the 16th write, count=16; a 17th write of 0xDEADBEEF is dropped.
- Drain: rinc=1 for 16 cycles after the fill -> rdata sequence 0x0..0xF, one cycle after each accepted read; rempty=1 after the last read; further rinc leaves rdata=0xF.
- Concurrent streaming: winc=rinc=1 continuously for 40 cycles with an incrementing wdata from 0x100 -> rdata reproduces the sequence in order across the pointer wrap; flags never both set; no loss or duplication.
- Boundaries:
  - Simultaneous winc/rinc when empty -> only the write is taken, count=1.
  - Simultaneous winc/rinc when full -> only the read is taken, count=15.
- Mid-operation reset: write 5 words, assert wrst for 1 cycle -> count=0, rempty=1; the next written 0xA5A5A5A5 is the first word read back.

Source files
------------

// File: rtl/sync_fifo_top.sv
// Single-clock 16x32 FIFO with a registered read port and registered full/empty/count flags.
// Pointers carry one extra wrap bit, so full and empty are told apart by that bit alone.
module sync_fifo_top #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic [ASIZE:0]   count
);

  localparam int DEPTH = 2 ** ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_next, rptr_next;
  logic             we, re;

  assign we = winc & ~wfull;
  assign re = rinc & ~rempty;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    wptr_next = wptr;
    rptr_next = rptr;
    if (we) wptr_next = wptr + 1'b1;
    if (re) rptr_next = rptr + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr   <= '0;
      rptr   <= '0;
      rdata  <= '0;
      wfull  <= 1'b0;
      rempty <= 1'b1;
      count  <= '0;
    end else begin
      wptr   <= wptr_next;
      rptr   <= rptr_next;
      if (re) rdata <= mem[rptr[ASIZE-1:0]];
      // Flags come from the next-state pointers so they line up with the pointer update.
      rempty <= (wptr_next == rptr_next);
      wfull  <= (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
      count  <= wptr_next - rptr_next;
    end
  end

  // NOTE: the storage array has no reset; its contents are meaningless until written.
  always_ff @(posedge wclk) begin
    if (we && !wrst) mem[wptr[ASIZE-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_sync_fifo_top.sv
// Self-checking bench for sync_fifo_top: a table of hand-computed vectors for reset/fill/drain,
// then model-checked sequences for streaming across the wrap, simultaneous access and mid-run reset.
module tb_sync_fifo_top;

  logic        wclk = 1'b0;
  logic        wrst, winc, rinc;
  logic [31:0] wdata, rdata;
  logic        wfull, rempty;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo_top dut (
    .wclk  (wclk),
    .wrst  (wrst),
    .winc  (winc),
    .wdata (wdata),
    .rinc  (rinc),
    .rdata (rdata),
    .wfull (wfull),
    .rempty(rempty),
    .count (count)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic        rst;
    logic        winc;
    logic        rinc;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_full;
    logic        exp_empty;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the sequenced tests.
  logic [31:0] m_q[$];
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic wi, input logic ri, input logic [31:0] wd,
                         input logic [31:0] erd, input logic ef, input logic ee, input logic [4:0] ec);
    vec_t v;
    v.rst = r; v.winc = wi; v.rinc = ri; v.wdata = wd;
    v.exp_rdata = erd; v.exp_full = ef; v.exp_empty = ee; v.exp_count = ec;
    vecs.push_back(v);
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic wi, input logic ri, input logic [31:0] wd);
    wrst = r; winc = wi; rinc = ri; wdata = wd;
    @(posedge wclk);
    #1;
  endtask

  // One cycle checked against the queue model.
  task automatic mcycle(input string name, input logic r, input logic wi, input logic ri,
                        input logic [31:0] wd);
    bit do_w, do_r;
    do_w = wi && (m_q.size() < 16);
    do_r = ri && (m_q.size() > 0);
    drive(r, wi, ri, wd);
    if (r) begin
      m_q.delete();
      m_rdata = '0;
    end else begin
      if (do_r) m_rdata = m_q.pop_front();
      if (do_w) m_q.push_back(wd);
    end
    check({name, ".rdata"},  rdata, m_rdata);
    check({name, ".count"},  32'(count), 32'(m_q.size()));
    check({name, ".wfull"},  32'(wfull), 32'(m_q.size() == 16));
    check({name, ".rempty"}, 32'(rempty), 32'(m_q.size() == 0));
    check({name, ".excl"},   32'(wfull & rempty), 32'd0);
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; rinc = 1'b0; wdata = '0;

    // Reset held two cycles with both requests active.
    add_vec(1, 1, 1, 32'h1111_1111, 32'h0, 0, 1, 5'd0);
    add_vec(1, 1, 1, 32'h2222_2222, 32'h0, 0, 1, 5'd0);
    // Fill with 0..15; wfull rises on the 16th write.
    for (int i = 0; i < 16; i++)
      add_vec(0, 1, 0, 32'(i), 32'h0, (i == 15), 0, 5'(i + 1));
    // 17th write is dropped.
    add_vec(0, 1, 0, 32'hDEAD_BEEF, 32'h0, 1, 0, 5'd16);
    // Drain: rdata follows 0..15 one cycle after each accepted read.
    for (int i = 0; i < 16; i++)
      add_vec(0, 0, 1, 32'h0, 32'(i), 0, (i == 15), 5'(15 - i));
    // Read while empty leaves rdata at 0xF.
    add_vec(0, 0, 1, 32'h0, 32'hF, 0, 1, 5'd0);
    add_vec(0, 0, 1, 32'h0, 32'hF, 0, 1, 5'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].winc, vecs[i].rinc, vecs[i].wdata);
      check($sformatf("vec%0d.rdata", i),  rdata,        vecs[i].exp_rdata);
      check($sformatf("vec%0d.wfull", i),  32'(wfull),   32'(vecs[i].exp_full));
      check($sformatf("vec%0d.rempty", i), 32'(rempty),  32'(vecs[i].exp_empty));
      check($sformatf("vec%0d.count", i),  32'(count),   32'(vecs[i].exp_count));
    end

    m_q.delete();
    m_rdata = 32'hF;

    // Simultaneous request while empty: only the write is taken.
    mcycle("empty_both", 0, 1, 1, 32'h0000_0055);
    check("empty_both.count1", 32'(count), 32'd1);
    check("empty_both.rdata_hold", rdata, 32'hF);
    mcycle("empty_both_rd", 0, 0, 1, 32'h0);
    check("empty_both_rd.data", rdata, 32'h0000_0055);

    // Continuous streaming across the pointer wrap.
    for (int i = 0; i < 40; i++)
      mcycle($sformatf("stream%0d", i), 0, 1, 1, 32'h100 + 32'(i));
    check("stream.last", rdata, 32'h100 + 32'd38);
    mcycle("stream_tail", 0, 0, 1, 32'h0);
    check("stream_tail.data", rdata, 32'h100 + 32'd39);

    // Fill, then simultaneous request while full: only the read is taken.
    for (int i = 0; i < 16; i++)
      mcycle($sformatf("fill2_%0d", i), 0, 1, 0, 32'h200 + 32'(i));
    check("full.flag", 32'(wfull), 32'd1);
    mcycle("full_both", 0, 1, 1, 32'hBAD0_BAD0);
    check("full_both.count15", 32'(count), 32'd15);
    check("full_both.rdata", rdata, 32'h200);
    for (int i = 0; i < 15; i++)
      mcycle($sformatf("drain2_%0d", i), 0, 0, 1, 32'h0);
    check("drain2.last", rdata, 32'h20F);

    // Mid-operation reset discards stored words.
    for (int i = 0; i < 5; i++)
      mcycle($sformatf("pre_rst%0d", i), 0, 1, 0, 32'h300 + 32'(i));
    mcycle("mid_rst", 1, 0, 0, 32'h0);
    check("mid_rst.count", 32'(count), 32'd0);
    check("mid_rst.rempty", 32'(rempty), 32'd1);
    mcycle("post_rst_wr", 0, 1, 0, 32'hA5A5_A5A5);
    mcycle("post_rst_rd", 0, 0, 1, 32'h0);
    check("post_rst.first", rdata, 32'hA5A5_A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
